cc_bus_arbiter: RTL
===================

// Module: cc_bus_arbiter
// PURPOSE
//  Shares one external async SRAM/peripheral bus between NUM_REQ on-chip requesters (CPU, video, DMA...).
//  Round-robin arbitration, then a fixed SETUP/ACCESS/DONE strobe sequence with programmable wait states.
//  Drives the direction select of the CC_Bidir data-pin instance: bus_sel_in=1 read/float, 0 drive.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  ADDR_WIDTH  16  external address width
//  DATA_WIDTH  8   external data width
//  WAIT_CYCLES 2   extra ACCESS cycles beyond the first (0..15)
// PORTS
//  clk         in   1                     system clock, all logic on posedge
//  reset       in   1                     synchronous, active-high
//  req         in   NUM_REQ               per-requester request, held until done
//  wr          in   NUM_REQ               per-requester 1=write 0=read
//  addr        in   NUM_REQ*ADDR_WIDTH    flattened, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  wdata       in   NUM_REQ*DATA_WIDTH    flattened write data, same packing
//  grant       out  NUM_REQ               one-hot owner, SETUP through DONE
//  done        out  1                     1-cycle pulse: transaction of granted requester complete
//  rdata       out  DATA_WIDTH            read data, valid while done=1, holds until next read
//  bus_addr    out  ADDR_WIDTH            external address
//  bus_wdata   out  DATA_WIDTH            to CC_Bidir out
//  bus_rdata   in   DATA_WIDTH            from CC_Bidir in
//  bus_sel_in  out  1                     to CC_Bidir sel_in
//  bus_oe_n    out  1                     read strobe, active low
//  bus_we_n    out  1                     write strobe, active low
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, grant=0, done=0, rdata=0, bus_addr=0, bus_wdata=0, bus_sel_in=1, bus_oe_n=1, bus_we_n=1.
//  Reset mid-transaction: next edge aborts; strobes released, bus_sel_in=1, no done pulse.
//  IDLE: if |req, winner = first set req at index ptr, ptr+1, ... mod NUM_REQ.
//    Latch winner, addr, wdata, wr into registers -> SETUP. Else stay.
//  SETUP (1 cycle): grant=onehot(winner), bus_addr valid, bus_sel_in=~wr, both strobes high.
//  ACCESS (WAIT_CYCLES+1 cycles, down-counter): bus_oe_n=0 (read) or bus_we_n=0 (write).
//    Addr/data/sel stable. On the last ACCESS edge, rdata<=bus_rdata if read.
//  DONE (1 cycle): done=1, grant held, strobes high, bus_addr/bus_wdata held.
//    bus_sel_in stays 0 for writes (data hold), then 1. ptr<=winner+1 (wraps at NUM_REQ) -> IDLE.
//  Latency: req sampled in IDLE at edge t -> done high in cycle t+WAIT_CYCLES+3. Min gap between transactions: 1 IDLE cycle.
//  Requester drops req on the edge ending done; req still high in IDLE is a new transaction.
//  req deassert/change during SETUP..DONE ignored (inputs already latched); no abort.
//  req bits of non-granted requesters never alter grant mid-transaction.
//  Strobes never both low; bus_sel_in=0 never coincides with bus_oe_n=0.
// CONFIGURATION
//  CC_BUS_ARB_FIXED_PRIO0_EN defined: requester 0 always wins if req[0]=1 in IDLE.
//    Remaining requesters round-robin; ptr is not updated when 0 wins.
//  Undefined: pure round-robin over all NUM_REQ as above.
// STRUCTURE
//  cc_bus_defs.vh: state codes (IDLE=0, SETUP=1, ACCESS=2, DONE=3), state width, WAIT counter width (4).
//  Sub-module cc_rr_pick: combinational (req, ptr) -> winner index + any flag; instantiated once.
//  Top: FSM, wait counter, latched request registers, rdata register, output decode.
// TESTING
//  Single read, req[2]=1, wr=0, addr=0x1234, bus_rdata=0x5A, WAIT=2 -> grant=0b0100 5 cycles, oe_n low 3, done at t+5, rdata=0x5A.
//  Single write, req[1], wdata=0xC3 -> we_n low 3 cycles, bus_sel_in=0 SETUP..DONE, bus_wdata=0xC3, oe_n stays 1.
//  All 4 req held continuously -> grants in order 0,1,2,3,0; each done exactly once per grant.
//  Reset asserted during ACCESS -> next cycle all strobes 1, grant=0, no done; next req starts from ptr=0.
//  req[3] drops during ACCESS, addr changes -> transaction completes with latched addr, done pulses.
//  With CC_BUS_ARB_FIXED_PRIO0_EN, req[0] and req[1] held -> 0 wins every arbitration, 1 starved.
//    Without the macro: alternation 0,1,0,1.

Source files
------------

// File: rtl/cc_bus_arbiter_pkg.sv
// Shared types for the external bus arbiter: FSM state codes,
// wait-counter width and a small index helper.
package cc_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } arb_state_t;

   localparam int WAIT_W = 4;

   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cc_bus_arbiter_if.sv
// Requester handshake plus external async bus pins of the arbiter.
// master = arbiter side, slave = requesters and pin/memory side.
interface cc_bus_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            wr;
   logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]            grant;
   logic                          done;
   logic [DATA_WIDTH-1:0]         rdata;
   logic [ADDR_WIDTH-1:0]         bus_addr;
   logic [DATA_WIDTH-1:0]         bus_wdata;
   logic [DATA_WIDTH-1:0]         bus_rdata;
   logic                          bus_sel_in;
   logic                          bus_oe_n;
   logic                          bus_we_n;

   modport master (
      input  req, wr, addr, wdata, bus_rdata,
      output grant, done, rdata, bus_addr, bus_wdata,
      output bus_sel_in, bus_oe_n, bus_we_n
   );

   modport slave (
      output req, wr, addr, wdata, bus_rdata,
      input  grant, done, rdata, bus_addr, bus_wdata,
      input  bus_sel_in, bus_oe_n, bus_we_n
   );
endinterface

// File: rtl/cc_bus_arbiter_rr_pick.sv
// Round-robin winner select starting at ptr.
// CC_BUS_ARB_FIXED_PRIO0_EN: requester 0 wins outright when requesting.
module cc_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [PW-1:0]      winner,
   output logic               any
);

   logic [NUM_REQ-1:0] cand;
   int                 idx;

`ifdef CC_BUS_ARB_FIXED_PRIO0_EN
   assign cand = {req[NUM_REQ-1:1], 1'b0};
`else
   assign cand = req;
`endif

   // Scan from the farthest offset back so the nearest one wins.
   always_comb begin
      winner = '0;
      any    = |req;
      idx    = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (cand[idx]) winner = PW'(idx);
      end
`ifdef CC_BUS_ARB_FIXED_PRIO0_EN
      if (req[0]) winner = '0;
`endif
   end

endmodule

// File: rtl/cc_bus_arbiter.sv
// Round-robin owner of one external async bus: SETUP/ACCESS/DONE strobes.
// Optional fixed priority for requester 0: CC_BUS_ARB_FIXED_PRIO0_EN.
module cc_bus_arbiter
   import cc_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input logic             clk,
   input logic             reset,
   cc_bus_arbiter_if.master bus
);

   localparam int PW = $clog2(NUM_REQ);

   arb_state_t            state_q, state_d;
   logic [PW-1:0]         ptr_q, win_q, pick_win;
   logic                  pick_any;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [WAIT_W-1:0]     cnt_q;
   logic [NUM_REQ-1:0]    win_oh, grant;
   logic                  done, oe_n, we_n, sel_in;

   cc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .winner (pick_win),
      .any    (pick_any)
   );

   assign win_oh = NUM_REQ'(1) << win_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant   = '0;
      done    = 1'b0;
      oe_n    = 1'b1;
      we_n    = 1'b1;
      sel_in  = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            grant   = win_oh;
            sel_in  = ~wr_q;
         end
         ST_ACCESS: begin
            if (cnt_q == '0) state_d = ST_DONE;
            grant  = win_oh;
            sel_in = ~wr_q;
            oe_n   = wr_q;
            we_n   = ~wr_q;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            grant   = win_oh;
            done    = 1'b1;
            sel_in  = ~wr_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q   <= '0;
         win_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (state_q == ST_IDLE && pick_any) begin
            win_q   <= pick_win;
            wr_q    <= bus.wr[pick_win];
            addr_q  <= bus.addr[pick_win*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= bus.wdata[pick_win*DATA_WIDTH +: DATA_WIDTH];
         end
         if (state_q == ST_SETUP)
            cnt_q <= WAIT_W'(WAIT_CYCLES);
         else if (state_q == ST_ACCESS && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
         if (state_q == ST_ACCESS && cnt_q == '0 && !wr_q)
            rdata_q <= bus.bus_rdata;
`ifdef CC_BUS_ARB_FIXED_PRIO0_EN
         // A priority win by requester 0 leaves the rotation untouched.
         if (state_q == ST_DONE && win_q != '0)
`else
         if (state_q == ST_DONE)
`endif
            ptr_q <= PW'(next_idx(int'(win_q), NUM_REQ));
      end
   end

   assign bus.grant      = grant;
   assign bus.done       = done;
   assign bus.rdata      = rdata_q;
   assign bus.bus_addr   = addr_q;
   assign bus.bus_wdata  = wdata_q;
   assign bus.bus_sel_in = sel_in;
   assign bus.bus_oe_n   = oe_n;
   assign bus.bus_we_n   = we_n;

endmodule
